// File: rtl/step_pulse_rx_if.sv
// Purpose: signal bundle between a step-pulse source/consumer and the step_pulse_rx receiver.
// Latency: none, wires only.
// Backpressure: none; the receiver is a pure observer and its outputs carry no ready.
//
// Ports (as seen from the receiver, modport slave):
//   pulse_in  in   asynchronous step-pulse line
//   invert    in   1: line is inverted before measurement
//   clr       in   synchronous clear of all measurement state
//   n_target  in   expected pulse count, 0 disables done
//   period    out  last rising-to-rising period in clk cycles
//   width     out  last high time in clk cycles
//   count     out  rising edges since reset/clr, saturating
//   d_v       out  one-clock strobe, period/width just updated
//   done      out  sticky, count reached n_target
//   timeout   out  sticky, pulse train lost while active
//   busy      out  measurement in progress
interface step_pulse_rx_if #(
  parameter int SIZE = 16
);
  logic            pulse_in;
  logic            invert;
  logic            clr;
  logic [SIZE-1:0] n_target;
  logic [SIZE-1:0] period;
  logic [SIZE-1:0] width;
  logic [SIZE-1:0] count;
  logic            d_v;
  logic            done;
  logic            timeout;
  logic            busy;

  modport master (
    output pulse_in, invert, clr, n_target,
    input  period, width, count, d_v, done, timeout, busy
  );

  modport slave (
    input  pulse_in, invert, clr, n_target,
    output period, width, count, d_v, done, timeout, busy
  );
endinterface

// File: rtl/step_pulse_rx.sv
// Purpose: step-pulse receiver; measures period and high width, counts rises, flags target count and pulse loss.
// Latency: a pulse_in edge is acted on SYNC_STAGES+1 clocks later; all outputs are registered.
// Backpressure: none; free-running observer, d_v is a one-clock strobe with no ready.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low
//   bus    step_pulse_rx_if.slave: pulse_in/invert/clr/n_target in,
//          period/width/count/d_v/done/timeout/busy out
module step_pulse_rx #(
  parameter int SIZE        = 16,
  parameter int TIMEOUT     = 65000,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  step_pulse_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] ALL_ONES = '1;
  localparam logic [SIZE-1:0] TMO      = SIZE'(TIMEOUT);
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;
  logic                   p_d_q;
  logic                   rise;
  logic                   fall;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] period_q, period_d;
  logic [SIZE-1:0] width_q, width_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [SIZE-1:0] cnt_inc;
  logic [SIZE-1:0] count_inc;
  logic            dv_q, dv_d;
  logic            done_q, done_d;
  logic            tmo_q, tmo_d;
  logic            bump;

  // Synchronizer and edge-detect history. p_d keeps running through clr so a
  // line that is already high when clr drops is not mistaken for a new rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      p_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
      p_d_q  <= p;
    end
  end

  assign p    = sync_q[SYNC_STAGES-1] ^ bus.invert;
  assign rise = p & ~p_d_q;
  assign fall = ~p & p_d_q;

  // Both counters saturate rather than wrap.
  assign cnt_inc   = (cnt_q == ALL_ONES)   ? cnt_q   : cnt_q + ONE;
  assign count_inc = (count_q == ALL_ONES) ? count_q : count_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      width_q  <= '0;
      count_q  <= '0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      width_q  <= width_d;
      count_q  <= count_d;
      dv_q     <= dv_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    width_d  = width_q;
    count_d  = count_q;
    dv_d     = 1'b0;
    done_d   = done_q;
    tmo_d    = tmo_q;
    bump     = 1'b0;

    if (bus.clr) begin
      // clr wins over any edge or timeout seen on the same clock.
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      width_d  = '0;
      count_d  = '0;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // First rise has no predecessor, so it starts timing but gives no d_v.
          if (rise) begin
            cnt_d   = ONE;
            bump    = 1'b1;
            state_d = HIGH;
          end
        end
        HIGH: begin
          cnt_d = cnt_inc;
          if (fall) begin
            width_d = cnt_q;
            state_d = LOW;
          end else if (cnt_q == TMO) begin
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        LOW: begin
          cnt_d = cnt_inc;
          if (rise) begin
            period_d = cnt_q;
            dv_d     = 1'b1;
            cnt_d    = ONE;
            bump     = 1'b1;
            state_d  = HIGH;
          end else if (cnt_q == TMO) begin
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // done is judged only when a rise is counted, so lowering n_target
      // beneath the current count never fires it on its own.
      if (bump) begin
        count_d = count_inc;
        if ((bus.n_target != '0) && (count_inc == bus.n_target)) begin
          done_d = 1'b1;
        end
      end
    end
  end

  assign bus.period  = period_q;
  assign bus.width   = width_q;
  assign bus.count   = count_q;
  assign bus.d_v     = dv_q;
  assign bus.done    = done_q;
  assign bus.timeout = tmo_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
